// File: rtl/fetch_pc_gen.sv
// Fetch-stage PC generator: drives N lane PCs to the BTB, forms the fetch bundle and picks the next fetch PC.
// Optional feature macro: FETCH_BTB_PREDICT_EN (BTB-driven taken-lane prediction; static not-taken when undefined).
module fetch_pc_gen #(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          SEQ_BITS = 4,
    parameter int          N        = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    output logic [N-1:0][31:0]      PCs,
    input  logic [N-1:0][31:0]      target_PCs,
    input  logic [N-1:0]            btb_hits,
    input  logic                    icache_valid,
    input  logic                    fetch_ready,
    input  logic                    redirect_valid,
    input  logic [31:0]             redirect_PC,
    output logic [N-1:0]            fetch_valid,
    output logic [N-1:0][31:0]      fetch_PCs,
    output logic [N-1:0]            pred_taken,
    output logic [31:0]             pred_target,
    output logic [SEQ_BITS-1:0]     fetch_seq
);

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        HOLD
    } state_e;

    state_e              state_q, state_d;
    logic [31:0]         fetch_pc_q, fetch_pc_d;
    logic [SEQ_BITS-1:0] fetch_seq_q, fetch_seq_d;

    logic [N-1:0]        lane_valid;
    logic [N-1:0]        lane_taken;
    logic [31:0]         taken_target;
    logic                squash;
    logic                stall;
    logic                accept;

`ifndef FETCH_BTB_PREDICT_EN
    logic unused_btb;
    assign unused_btb = ^{btb_hits, target_PCs};
`endif

    always_comb begin
        for (int i = 0; i < N; i++) begin
            PCs[i] = fetch_pc_q + 32'(4 * i);
        end
    end

    assign fetch_PCs = PCs;

    // Lanes up to and including the first predicted-taken lane are valid; later lanes are cut.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
        lane_valid   = '0;
        lane_taken   = '0;
        taken_target = '0;
        for (int i = 0; i < N; i++) begin
            lane_valid[i] = ~|lane_taken;
`ifdef FETCH_BTB_PREDICT_EN
            if (~|lane_taken && btb_hits[i]) begin
                lane_taken[i] = 1'b1;
                taken_target  = target_PCs[i];
            end
`endif
        end
    end

    assign squash      = (state_q == BOOT) || !icache_valid || redirect_valid;
    assign fetch_valid = squash ? '0 : lane_valid;
    assign pred_taken  = squash ? '0 : lane_taken;
    assign pred_target = (|pred_taken) ? taken_target : 32'h0;
    assign stall       = !(icache_valid && fetch_ready);
    assign accept      = (|fetch_valid) && fetch_ready;
    assign fetch_seq   = fetch_seq_q;

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        fetch_seq_d = fetch_seq_q;

        unique case (state_q)
            BOOT:    state_d = FETCH;
            FETCH:   if (stall) state_d = HOLD;
            HOLD:    if (!stall || redirect_valid) state_d = FETCH;
            default: state_d = BOOT;
        endcase

        // A redirect outranks everything; fetch_valid is already squashed so accept is low.
        if (redirect_valid) begin
            fetch_pc_d = redirect_PC;
        end else if (accept) begin
            fetch_pc_d  = (|pred_taken) ? pred_target : fetch_pc_q + 32'(4 * N);
            fetch_seq_d = fetch_seq_q + SEQ_BITS'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= BOOT;
            fetch_pc_q  <= RESET_PC;
            fetch_seq_q <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            fetch_seq_q <= fetch_seq_d;
        end
    end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed self-checking bench for fetch_pc_gen with RESET_PC=0x100, N=2, SEQ_BITS=4.
module tb_fetch_pc_gen;

    logic              clock;
    logic              reset;
    logic [1:0][31:0]  PCs;
    logic [1:0][31:0]  target_PCs;
    logic [1:0]        btb_hits;
    logic              icache_valid;
    logic              fetch_ready;
    logic              redirect_valid;
    logic [31:0]       redirect_PC;
    logic [1:0]        fetch_valid;
    logic [1:0][31:0]  fetch_PCs;
    logic [1:0]        pred_taken;
    logic [31:0]       pred_target;
    logic [3:0]        fetch_seq;

    int vec_count  = 0;
    int miss_count = 0;
    logic [31:0] base;

    fetch_pc_gen #(
        .RESET_PC (32'h100),
        .SEQ_BITS (4),
        .N        (2)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .PCs            (PCs),
        .target_PCs     (target_PCs),
        .btb_hits       (btb_hits),
        .icache_valid   (icache_valid),
        .fetch_ready    (fetch_ready),
        .redirect_valid (redirect_valid),
        .redirect_PC    (redirect_PC),
        .fetch_valid    (fetch_valid),
        .fetch_PCs      (fetch_PCs),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .fetch_seq      (fetch_seq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one clock edge; inputs change and outputs are sampled in the low phase.
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1; icache_valid = 1'b1; fetch_ready = 1'b1;
        redirect_valid = 1'b0; redirect_PC = '0; btb_hits = '0; target_PCs = '0;
        tick(); tick(); #1;
        vec_count++; if (fetch_valid !== 2'b00) begin miss_count++; $display("FAIL rst_valid: got %b expected 00", fetch_valid); end
        vec_count++; if (pred_taken !== 2'b00) begin miss_count++; $display("FAIL rst_pred_taken: got %b expected 00", pred_taken); end
        vec_count++; if (pred_target !== 32'h0) begin miss_count++; $display("FAIL rst_pred_target: got %h expected 0", pred_target); end
        vec_count++; if (fetch_seq !== 4'd0) begin miss_count++; $display("FAIL rst_seq: got %0d expected 0", fetch_seq); end
        vec_count++; if (PCs !== {32'h104, 32'h100}) begin miss_count++; $display("FAIL rst_pcs: got %h expected 104_100", PCs); end
        reset = 1'b0; #1;
        vec_count++; if (fetch_valid !== 2'b00) begin miss_count++; $display("FAIL boot_valid: got %b expected 00", fetch_valid); end
        tick(); #1;
        vec_count++; if (PCs !== {32'h104, 32'h100}) begin miss_count++; $display("FAIL first_pcs: got %h expected 104_100", PCs); end
        vec_count++; if (fetch_PCs !== {32'h104, 32'h100}) begin miss_count++; $display("FAIL first_fetch_pcs: got %h expected 104_100", fetch_PCs); end
        vec_count++; if (fetch_valid !== 2'b11) begin miss_count++; $display("FAIL first_valid: got %b expected 11", fetch_valid); end
        vec_count++; if (fetch_seq !== 4'd0) begin miss_count++; $display("FAIL first_seq: got %0d expected 0", fetch_seq); end
        tick(); #1;
        vec_count++; if (PCs !== {32'h10C, 32'h108}) begin miss_count++; $display("FAIL second_pcs: got %h expected 10C_108", PCs); end
        vec_count++; if (fetch_seq !== 4'd1) begin miss_count++; $display("FAIL second_seq: got %0d expected 1", fetch_seq); end
    endtask

    task automatic test_predict();
        target_PCs = {32'h300, 32'h200};
`ifdef FETCH_BTB_PREDICT_EN
        btb_hits = 2'b01; #1;
        vec_count++; if (fetch_valid !== 2'b01) begin miss_count++; $display("FAIL taken_valid: got %b expected 01", fetch_valid); end
        vec_count++; if (pred_taken !== 2'b01) begin miss_count++; $display("FAIL taken_lane: got %b expected 01", pred_taken); end
        vec_count++; if (pred_target !== 32'h200) begin miss_count++; $display("FAIL taken_target: got %h expected 200", pred_target); end
        tick(); btb_hits = '0; #1;
        base = 32'h200;
`else
        btb_hits = 2'b11; #1;
        vec_count++; if (fetch_valid !== 2'b11) begin miss_count++; $display("FAIL static_valid: got %b expected 11", fetch_valid); end
        vec_count++; if (pred_taken !== 2'b00) begin miss_count++; $display("FAIL static_taken: got %b expected 00", pred_taken); end
        vec_count++; if (pred_target !== 32'h0) begin miss_count++; $display("FAIL static_target: got %h expected 0", pred_target); end
        tick(); btb_hits = '0; #1;
        base = 32'h110;
`endif
        vec_count++; if (PCs !== {base + 32'h4, base}) begin miss_count++; $display("FAIL predict_next_pcs: got %h expected %h_%h", PCs, base + 32'h4, base); end
        vec_count++; if (fetch_seq !== 4'd2) begin miss_count++; $display("FAIL predict_seq: got %0d expected 2", fetch_seq); end
    endtask

    task automatic test_stall();
        fetch_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            vec_count++; if (PCs !== {base + 32'h4, base}) begin miss_count++; $display("FAIL stall_pcs[%0d]: got %h expected %h_%h", c, PCs, base + 32'h4, base); end
            vec_count++; if (fetch_seq !== 4'd2) begin miss_count++; $display("FAIL stall_seq[%0d]: got %0d expected 2", c, fetch_seq); end
            tick();
        end
        fetch_ready = 1'b1; #1;
        vec_count++; if (fetch_valid !== 2'b11) begin miss_count++; $display("FAIL release_valid: got %b expected 11", fetch_valid); end
        vec_count++; if (PCs !== {base + 32'h4, base}) begin miss_count++; $display("FAIL release_pcs: got %h expected %h_%h", PCs, base + 32'h4, base); end
        tick(); #1;
        vec_count++; if (PCs !== {base + 32'hC, base + 32'h8}) begin miss_count++; $display("FAIL after_stall_pcs: got %h expected %h_%h", PCs, base + 32'hC, base + 32'h8); end
        vec_count++; if (fetch_seq !== 4'd3) begin miss_count++; $display("FAIL after_stall_seq: got %0d expected 3", fetch_seq); end
    endtask

    task automatic test_redirect();
        redirect_valid = 1'b1; redirect_PC = 32'h400; #1;
        vec_count++; if (fetch_valid !== 2'b00) begin miss_count++; $display("FAIL redir_squash: got %b expected 00", fetch_valid); end
        tick(); redirect_valid = 1'b0; #1;
        vec_count++; if (PCs !== {32'h404, 32'h400}) begin miss_count++; $display("FAIL redir_pcs: got %h expected 404_400", PCs); end
        vec_count++; if (fetch_valid !== 2'b11) begin miss_count++; $display("FAIL redir_valid: got %b expected 11", fetch_valid); end
        vec_count++; if (fetch_seq !== 4'd3) begin miss_count++; $display("FAIL redir_seq: got %0d expected 3", fetch_seq); end
        tick();
    endtask

    task automatic test_icache_miss();
        icache_valid = 1'b0; #1;
        vec_count++; if (fetch_valid !== 2'b00) begin miss_count++; $display("FAIL miss_valid: got %b expected 00", fetch_valid); end
        vec_count++; if (PCs !== {32'h40C, 32'h408}) begin miss_count++; $display("FAIL miss_pcs: got %h expected 40C_408", PCs); end
        vec_count++; if (fetch_seq !== 4'd4) begin miss_count++; $display("FAIL miss_seq: got %0d expected 4", fetch_seq); end
        tick(); #1;
        vec_count++; if (PCs !== {32'h40C, 32'h408}) begin miss_count++; $display("FAIL miss_hold_pcs: got %h expected 40C_408", PCs); end
        redirect_valid = 1'b1; redirect_PC = 32'h500;
        tick(); icache_valid = 1'b1; redirect_valid = 1'b0; #1;
        vec_count++; if (PCs !== {32'h504, 32'h500}) begin miss_count++; $display("FAIL miss_redir_pcs: got %h expected 504_500", PCs); end
        vec_count++; if (fetch_valid !== 2'b11) begin miss_count++; $display("FAIL miss_redir_valid: got %b expected 11", fetch_valid); end
        vec_count++; if (fetch_seq !== 4'd4) begin miss_count++; $display("FAIL miss_redir_seq: got %0d expected 4", fetch_seq); end
        tick();
    endtask

    task automatic test_pc_wrap();
        redirect_valid = 1'b1; redirect_PC = 32'hFFFF_FFF8;
        tick(); redirect_valid = 1'b0; #1;
        vec_count++; if (PCs !== {32'hFFFF_FFFC, 32'hFFFF_FFF8}) begin miss_count++; $display("FAIL wrap_top_pcs: got %h expected FFFFFFFC_FFFFFFF8", PCs); end
        vec_count++; if (fetch_seq !== 4'd5) begin miss_count++; $display("FAIL wrap_top_seq: got %0d expected 5", fetch_seq); end
        tick(); #1;
        vec_count++; if (PCs !== {32'h4, 32'h0}) begin miss_count++; $display("FAIL wrap_zero_pcs: got %h expected 4_0", PCs); end
    endtask

    task automatic test_seq_wrap();
        logic [3:0] exp_seq;
        logic [31:0] exp_pc;
        for (int k = 0; k < 10; k++) begin
            exp_seq = 4'(6 + k);
            exp_pc  = 32'(8 * k);
            #1;
            vec_count++; if (fetch_seq !== exp_seq) begin miss_count++; $display("FAIL seq_run[%0d]: got %0d expected %0d", k, fetch_seq, exp_seq); end
            vec_count++; if (PCs !== {exp_pc + 32'h4, exp_pc}) begin miss_count++; $display("FAIL seq_run_pcs[%0d]: got %h expected %h_%h", k, PCs, exp_pc + 32'h4, exp_pc); end
            tick();
        end
        #1;
        vec_count++; if (fetch_seq !== 4'd0) begin miss_count++; $display("FAIL seq_wrap: got %0d expected 0", fetch_seq); end
        vec_count++; if (PCs !== {32'h54, 32'h50}) begin miss_count++; $display("FAIL seq_wrap_pcs: got %h expected 54_50", PCs); end
    endtask

    task automatic test_reset_mid_stall();
        fetch_ready = 1'b0;
        tick();
        reset = 1'b1; redirect_valid = 1'b1; redirect_PC = 32'h700;
        tick(); #1;
        vec_count++; if (PCs !== {32'h104, 32'h100}) begin miss_count++; $display("FAIL rst_stall_pcs: got %h expected 104_100", PCs); end
        vec_count++; if (fetch_seq !== 4'd0) begin miss_count++; $display("FAIL rst_stall_seq: got %0d expected 0", fetch_seq); end
        reset = 1'b0; redirect_valid = 1'b0; fetch_ready = 1'b1; #1;
        vec_count++; if (fetch_valid !== 2'b00) begin miss_count++; $display("FAIL rst_stall_boot: got %b expected 00", fetch_valid); end
        tick(); #1;
        vec_count++; if (fetch_valid !== 2'b11) begin miss_count++; $display("FAIL rst_stall_valid: got %b expected 11", fetch_valid); end
        vec_count++; if (PCs !== {32'h104, 32'h100}) begin miss_count++; $display("FAIL rst_stall_restart: got %h expected 104_100", PCs); end
    endtask

    task automatic test_redirect_in_boot();
        reset = 1'b1;
        tick();
        reset = 1'b0; redirect_valid = 1'b1; redirect_PC = 32'h800; #1;
        vec_count++; if (fetch_valid !== 2'b00) begin miss_count++; $display("FAIL boot_redir_valid: got %b expected 00", fetch_valid); end
        tick(); redirect_valid = 1'b0; #1;
        vec_count++; if (PCs !== {32'h804, 32'h800}) begin miss_count++; $display("FAIL boot_redir_pcs: got %h expected 804_800", PCs); end
        vec_count++; if (fetch_valid !== 2'b11) begin miss_count++; $display("FAIL boot_redir_fetch: got %b expected 11", fetch_valid); end
        vec_count++; if (fetch_seq !== 4'd0) begin miss_count++; $display("FAIL boot_redir_seq: got %0d expected 0", fetch_seq); end
    endtask

    initial begin
        reset = 1'b1; icache_valid = 1'b0; fetch_ready = 1'b0;
        redirect_valid = 1'b0; redirect_PC = '0; btb_hits = '0; target_PCs = '0;
        base = '0;
        @(negedge clock);
        test_reset();
        test_predict();
        test_stall();
        test_redirect();
        test_icache_miss();
        test_pc_wrap();
        test_seq_wrap();
        test_reset_mid_stall();
        test_redirect_in_boot();
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
